// File: rtl/uart_game_rx.sv
// Game-status UART receiver: 8N1 deserialiser with framing check, plus a
// two-byte packet parser that turns peer commands into game-state flags.
module uart_game_rx #(
    parameter int unsigned CLKS_PER_BIT = 564,
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter logic [7:0]  CMD_OVER     = 8'h01,
    parameter logic [7:0]  CMD_START    = 8'h02
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       rx,
    input  logic       peer_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       cmd_err,
    output logic       peer_game_start,
    output logic       peer_game_over
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    typedef enum logic {
        P_HDR,
        P_CMD
    } p_state_t;

    logic             rx_meta;
    logic             rx_s;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_d;
    logic             valid_d;
    logic             ferr_d;

    p_state_t         pstate_q, pstate_d;
    logic             start_d;
    logic             cmderr_d;
    logic             over_d;

    // Two-flop synchroniser; resets to idle-high so reset exit never looks like a start bit
    always_ff @(posedge pclk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receiver state and output registers
    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            rx_data   <= data_d;
            rx_valid  <= valid_d;
            frame_err <= ferr_d;
        end
    end

    // Receiver next-state: mid-bit sampling driven by the bit counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = rx_data;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Parser state and flag registers
    always_ff @(posedge pclk) begin
        if (!rst) begin
            pstate_q        <= P_HDR;
            peer_game_start <= 1'b0;
            cmd_err         <= 1'b0;
            peer_game_over  <= 1'b0;
        end else begin
            pstate_q        <= pstate_d;
            peer_game_start <= start_d;
            cmd_err         <= cmderr_d;
            peer_game_over  <= over_d;
        end
    end

    // Parser next-state: header then command; a CMD_OVER set overrides peer_clr
    always_comb begin
        pstate_d = pstate_q;
        start_d  = 1'b0;
        cmderr_d = 1'b0;
        over_d   = peer_game_over;
        if (peer_clr) begin
            over_d = 1'b0;
        end
        if (frame_err) begin
            pstate_d = P_HDR;
        end else if (rx_valid) begin
            case (pstate_q)
                P_HDR: begin
                    if (rx_data == HEADER) begin
                        pstate_d = P_CMD;
                    end
                end
                P_CMD: begin
                    if (rx_data == HEADER) begin
                        pstate_d = P_CMD;
                    end else if (rx_data == CMD_OVER) begin
                        over_d   = 1'b1;
                        pstate_d = P_HDR;
                    end else if (rx_data == CMD_START) begin
                        start_d  = 1'b1;
                        over_d   = 1'b0;
                        pstate_d = P_HDR;
                    end else begin
                        cmderr_d = 1'b1;
                        pstate_d = P_HDR;
                    end
                end
                default: pstate_d = P_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_game_rx.sv
// Self-checking bench for uart_game_rx with a packet-level reference model.
module tb_uart_game_rx;

    localparam int unsigned CPB     = 16;
    localparam logic [7:0]  HDR     = 8'hA5;
    localparam logic [7:0]  C_OVER  = 8'h01;
    localparam logic [7:0]  C_START = 8'h02;

    logic       pclk     = 1'b0;
    logic       rst      = 1'b0;
    logic       rx       = 1'b1;
    logic       peer_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       cmd_err;
    logic       peer_game_start;
    logic       peer_game_over;

    uart_game_rx #(
        .CLKS_PER_BIT(CPB),
        .HEADER      (HDR),
        .CMD_OVER    (C_OVER),
        .CMD_START   (C_START)
    ) dut (
        .pclk           (pclk),
        .rst            (rst),
        .rx             (rx),
        .peer_clr       (peer_clr),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .frame_err      (frame_err),
        .cmd_err        (cmd_err),
        .peer_game_start(peer_game_start),
        .peer_game_over (peer_game_over)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    int unsigned cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // Observed events, sampled on the falling edge
    int          n_valid = 0, n_ferr = 0, n_cmderr = 0, n_start = 0;
    int          n_wide = 0, n_overlap = 0;
    int unsigned last_valid_cyc = 0;
    logic        p_valid = 0, p_ferr = 0, p_cmderr = 0, p_start = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];

    always @(negedge pclk) begin
        if (rx_valid) begin
            n_valid++;
            got_q.push_back(rx_data);
            last_valid_cyc = cyc;
        end
        if (frame_err)       n_ferr++;
        if (cmd_err)         n_cmderr++;
        if (peer_game_start) n_start++;
        if ((rx_valid && p_valid) || (frame_err && p_ferr) ||
            (cmd_err && p_cmderr) || (peer_game_start && p_start)) n_wide++;
        if (rx_valid && frame_err) n_overlap++;
        p_valid  = rx_valid;
        p_ferr   = frame_err;
        p_cmderr = cmd_err;
        p_start  = peer_game_start;
    end

    // Reference model: packet rules applied to each good byte
    bit m_hdr    = 0;
    bit m_over   = 0;
    int m_starts = 0;
    int m_cmderr = 0;

    task automatic model_byte(input logic [7:0] b);
        if (!m_hdr) begin
            m_hdr = (b == HDR);
        end else if (b == HDR) begin
            m_hdr = 1;
        end else begin
            m_hdr = 0;
            if (b == C_OVER)       m_over = 1;
            else if (b == C_START) begin m_starts++; m_over = 0; end
            else                   m_cmderr++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // Drive one 8N1 frame; good frames are queued as expected bytes
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop_ok;
        idle(CPB);
        rx = 1'b1;
        if (stop_ok) begin
            exp_q.push_back(b);
            model_byte(b);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle(3);
        checks++;
        if ({rx_data, rx_valid, frame_err, cmd_err, peer_game_start, peer_game_over} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 0",
                     {rx_data, rx_valid, frame_err, cmd_err, peer_game_start, peer_game_over});
        end
        rst = 1'b1;
        idle(20);
    endtask

    task automatic test_single_byte;
        int unsigned k;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        k = cyc;
        send_byte(8'h3C, 1);
        idle(4);
        checks++;
        if (n_valid - v0 !== 1) begin
            errors++; $display("FAIL single_valid_count: got %0d, want 1", n_valid - v0);
        end
        checks++;
        if (n_ferr - f0 !== 0) begin
            errors++; $display("FAIL single_ferr_count: got %0d, want 0", n_ferr - f0);
        end
        checks++;
        if (last_valid_cyc - k !== 155) begin
            errors++; $display("FAIL single_latency: got %0d, want 155", last_valid_cyc - k);
        end
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== 8'h3C) begin
            errors++; $display("FAIL single_data: got size %0d first %h, want 1 x 3c",
                               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_packets;
        int s0;
        s0 = n_start;
        send_byte(HDR, 1);
        send_byte(C_OVER, 1);
        idle(4);
        checks++;
        if (peer_game_over !== m_over) begin
            errors++; $display("FAIL pkt_over_set: got %b, want %b", peer_game_over, m_over);
        end
        send_byte(HDR, 1);
        send_byte(C_START, 1);
        idle(4);
        checks++;
        if (n_start - s0 !== 1) begin
            errors++; $display("FAIL pkt_start_pulse: got %0d, want 1", n_start - s0);
        end
        checks++;
        if (peer_game_over !== m_over) begin
            errors++; $display("FAIL pkt_over_clear: got %b, want %b", peer_game_over, m_over);
        end
        checks++;
        if (got_q !== exp_q) begin
            errors++; $display("FAIL pkt_bytes: got %p, want %p", got_q, exp_q);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_framing;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'h55, 0);
        rx = 1'b0;
        idle(40);
        rx = 1'b1;
        idle(16);
        m_hdr = 0;
        checks++;
        if (n_ferr - f0 !== 1) begin
            errors++; $display("FAIL frame_err_count: got %0d, want 1", n_ferr - f0);
        end
        checks++;
        if (n_valid - v0 !== 0) begin
            errors++; $display("FAIL frame_no_valid: got %0d, want 0", n_valid - v0);
        end
        send_byte(HDR, 1);
        send_byte(C_OVER, 1);
        idle(4);
        checks++;
        if (peer_game_over !== m_over || m_over !== 1'b1) begin
            errors++; $display("FAIL frame_then_over: got %b, want 1", peer_game_over);
        end
        checks++;
        if (got_q !== exp_q) begin
            errors++; $display("FAIL frame_bytes: got %p, want %p", got_q, exp_q);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_glitch_resync;
        int total0, c0;
        total0 = n_valid + n_ferr + n_cmderr + n_start;
        peer_clr = 1'b1;
        idle(1);
        peer_clr = 1'b0;
        m_over = 0;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        checks++;
        if (n_valid + n_ferr + n_cmderr + n_start - total0 !== 0) begin
            errors++; $display("FAIL glitch_strobes: got %0d, want 0",
                               n_valid + n_ferr + n_cmderr + n_start - total0);
        end
        checks++;
        if (peer_game_over !== m_over) begin
            errors++; $display("FAIL peer_clr_clears: got %b, want %b", peer_game_over, m_over);
        end
        send_byte(HDR, 1);
        send_byte(HDR, 1);
        send_byte(C_OVER, 1);
        idle(4);
        checks++;
        if (peer_game_over !== m_over) begin
            errors++; $display("FAIL resync_over: got %b, want %b", peer_game_over, m_over);
        end
        c0 = n_cmderr;
        send_byte(HDR, 1);
        send_byte(8'h7F, 1);
        idle(4);
        checks++;
        if (n_cmderr - c0 !== 1) begin
            errors++; $display("FAIL cmd_err_pulse: got %0d, want 1", n_cmderr - c0);
        end
        checks++;
        if (got_q !== exp_q) begin
            errors++; $display("FAIL resync_bytes: got %p, want %p", got_q, exp_q);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random_stream;
        int s0, c0, ms0, mc0;
        logic [7:0] b;
        s0 = n_start; c0 = n_cmderr; ms0 = m_starts; mc0 = m_cmderr;
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0: b = HDR;
                1: b = C_OVER;
                2: b = C_START;
                default: b = 8'($urandom);
            endcase
            send_byte(b, 1);
        end
        idle(4);
        checks++;
        if (got_q !== exp_q) begin
            errors++; $display("FAIL rand_bytes: got %p, want %p", got_q, exp_q);
        end
        checks++;
        if (n_start - s0 !== m_starts - ms0) begin
            errors++; $display("FAIL rand_starts: got %0d, want %0d", n_start - s0, m_starts - ms0);
        end
        checks++;
        if (n_cmderr - c0 !== m_cmderr - mc0) begin
            errors++; $display("FAIL rand_cmderr: got %0d, want %0d", n_cmderr - c0, m_cmderr - mc0);
        end
        checks++;
        if (peer_game_over !== m_over) begin
            errors++; $display("FAIL rand_over: got %b, want %b", peer_game_over, m_over);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_priority;
        bit timed_out;
        // Leave the parser in P_HDR with the flag clear
        send_byte(8'h00, 1);
        peer_clr = 1'b1;
        idle(1);
        peer_clr = 1'b0;
        m_over = 0;
        idle(2);
        timed_out = 1;
        fork
            begin
                send_byte(HDR, 1);
                send_byte(C_OVER, 1);
            end
            begin
                int seen;
                seen = 0;
                for (int t = 0; t < 2000; t++) begin
                    @(negedge pclk);
                    if (rx_valid) seen++;
                    if (seen == 2) begin
                        timed_out = 0;
                        peer_clr = 1'b1;
                        @(negedge pclk);
                        peer_clr = 1'b0;
                        break;
                    end
                end
            end
        join
        checks++;
        if (timed_out) begin
            errors++; $display("FAIL prio_wait: got no command byte within 2000 cycles, want one");
        end
        idle(4);
        checks++;
        if (peer_game_over !== 1'b1) begin
            errors++; $display("FAIL prio_set_wins: got %b, want 1", peer_game_over);
        end
        m_over = 1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midframe;
        int v0;
        send_byte(HDR, 1);
        idle(3);
        rx = 1'b0;
        idle(50);
        rst = 1'b0;
        rx  = 1'b1;
        idle(1);
        checks++;
        if ({rx_data, rx_valid, frame_err, cmd_err, peer_game_start, peer_game_over} !== 13'd0) begin
            errors++;
            $display("FAIL midframe_reset_outputs: got %h, want 0",
                     {rx_data, rx_valid, frame_err, cmd_err, peer_game_start, peer_game_over});
        end
        rst = 1'b1;
        m_hdr = 0; m_over = 0;
        got_q.delete();
        exp_q.delete();
        v0 = n_valid;
        idle(200);
        checks++;
        if (n_valid - v0 !== 0) begin
            errors++; $display("FAIL post_reset_quiet: got %0d, want 0", n_valid - v0);
        end
        send_byte(C_OVER, 1);
        idle(4);
        checks++;
        if (peer_game_over !== m_over) begin
            errors++; $display("FAIL header_lost_on_reset: got %b, want %b", peer_game_over, m_over);
        end
        send_byte(HDR, 1);
        send_byte(C_OVER, 1);
        idle(4);
        checks++;
        if (peer_game_over !== 1'b1 || m_over !== 1'b1) begin
            errors++; $display("FAIL post_reset_decode: got %b, want 1", peer_game_over);
        end
        checks++;
        if (got_q !== exp_q) begin
            errors++; $display("FAIL post_reset_bytes: got %p, want %p", got_q, exp_q);
        end
        checks++;
        if (n_wide !== 0 || n_overlap !== 0) begin
            errors++; $display("FAIL strobe_shape: got %0d wide, %0d overlap, want 0 and 0",
                               n_wide, n_overlap);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_packets();
        test_framing();
        test_glitch_resync();
        test_random_stream();
        test_priority();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_game_rx.md
# uart_game_rx

Receive-side counterpart of the game-status UART link. Deserialises 8N1 frames from the `rx` pin in the `pclk` domain and checks each byte for a framing error. Decodes two-byte game packets (header + command) from the peer board into game-state flags for the menu/background and HP logic. Sits beside the UART transmitter in `main`, fed directly from the `rx` pad.

## Interface
Parameters:
- `CLKS_PER_BIT`, 564: `pclk` cycles per bit (65 MHz / 115200); must be ≥ 8 and even.
- `HEADER`, 8'hA5: packet header byte.
- `CMD_OVER`, 8'h01: command code "peer game over".
- `CMD_START`, 8'h02: command code "peer game start".

Ports:
- `pclk`  in  1: pixel clock; the only clock.
- `rst`  in  1: synchronous, active-low reset.
- `rx`  in  1: asynchronous serial input; idles high.
- `peer_clr`  in  1: clears `peer_game_over`.
- `rx_data`  out  8: last good byte, LSB received first.
- `rx_valid`  out  1: one-cycle strobe; `rx_data` is new.
- `frame_err`  out  1: one-cycle strobe; stop bit was sampled low.
- `cmd_err`  out  1: one-cycle strobe; unknown command after header.
- `peer_game_start`  out  1: one-cycle strobe on a valid START packet.
- `peer_game_over`  out  1: sticky flag set by an OVER packet.

## Operation
- Synchroniser: two flops on `rx`, both reset to 1. All logic uses the synchronised value `rx_s`.
- Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. A bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) drive it.
  - IDLE: when `rx_s`==0, go to START and clear the counter.
  - START: at count CLKS_PER_BIT/2-1, sample `rx_s`. If 0, go to DATA and clear the counter. If 1, treat it as a glitch and return to IDLE with no strobe.
  - DATA: at each count CLKS_PER_BIT-1, shift `rx_s` into the MSB of the shift register. After index 7, go to STOP.
  - STOP: at count CLKS_PER_BIT-1, sample `rx_s`.
    - If 1: load `rx_data` and pulse `rx_valid`; go to IDLE.
    - If 0: pulse `frame_err`, discard the byte (`rx_data` is unchanged), and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This covers break conditions.
- Parser FSM states: P_HDR, P_CMD. It advances only on `rx_valid`.
  - P_HDR: byte==HEADER goes to P_CMD; any other byte is ignored.
  - P_CMD, byte==HEADER: stay in P_CMD (resync; the latest header wins).
  - P_CMD, byte==CMD_OVER: set `peer_game_over`; go to P_HDR.
  - P_CMD, byte==CMD_START: pulse `peer_game_start`, clear `peer_game_over`; go to P_HDR.
  - P_CMD, any other byte: pulse `cmd_err`; go to P_HDR.
  - A `frame_err` in any parser state forces P_HDR.
- `peer_clr` clears `peer_game_over`. If a set from CMD_OVER lands in the same cycle, the set wins.
- Reset, including a reset mid-frame, aborts everything:
  - Both FSMs return to IDLE / P_HDR; the counter and index go to 0.
  - `rx_data`=0; all strobes=0; `peer_game_over`=0.
  - The synchroniser flops go to 1, so no false start is detected on exit from reset.

## Timing
- Let t0 be the first `pclk` edge at which `rx_s`==0 in IDLE.
- Start is sampled at t0+CLKS_PER_BIT/2. Data bit i is sampled at t0+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT. Stop is sampled at t0+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
- `rx_valid` / `frame_err` are registered and assert in the cycle after the stop sample. They last exactly 1 cycle.
- `peer_game_start`, `cmd_err` and the `peer_game_over` set/clear take effect 1 cycle after the `rx_valid` of the command byte.
- Pad-to-`rx_s` latency is 2 cycles.
- The receiver re-arms in IDLE right after a good stop sample. Back-to-back frames with no idle time between them are therefore received without loss.
- Strobes never overlap within one byte; `rx_valid` and `frame_err` are mutually exclusive.

## Test plan
All benches use CLKS_PER_BIT=16.
- Single byte: send 8'h3C on `rx` with a correct stop bit -> `rx_valid` high for 1 cycle, `rx_data`=8'h3C, `frame_err`=0.
- Packets: send A5,01 -> `peer_game_over`=1. Then send A5,02 -> one `peer_game_start` pulse and `peer_game_over`=0. Back-to-back frames must all decode.
- Framing: send 8'h55 with stop bit 0, hold `rx` low for 40 cycles, then send A5,01 -> one `frame_err` pulse, no `rx_valid` for 55, `peer_game_over`=1 after the packet.
- Glitch/resync: pulse `rx` low for 4 cycles -> no strobes. Then send A5,A5,01 -> `peer_game_over`=1. Then send A5,7F -> one `cmd_err` pulse.
- Priority/reset: assert `peer_clr` in the same cycle the CMD_OVER set lands -> `peer_game_over` stays 1. Drop `rst` low for 1 cycle mid-frame -> all outputs 0, and the next clean A5,01 decodes normally.
